sram_ctrl: RTL

- Responder end of the instruction-bus RAM interface: accepts one word request at a time from the bus.
- Drives an external asynchronous 32-bit SRAM with programmable wait states.
- Returns read data and holds `ram_stall` high until the access completes.
- Sits between the instruction bus and the board SRAM pins. The SRAM data bus is split into in/out/oe for tristating at top level.

---
 rtl/sram_ctrl_pkg.sv | 37 +++
 rtl/sram_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_ctrl_pkg
// Description : Shared definitions for the asynchronous SRAM controller:
//               FSM state encodings, default wait-state count, wait-counter
//               width and a helper that clamps the wait count to a legal value.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        SRAM_IDLE   = 2'd0,
        SRAM_ACCESS = 2'd1,
        SRAM_DONE   = 2'd2
    } sram_state_e;

    localparam int SRAM_WAIT_DEFAULT = 2;

    // Wait counter width; the largest legal wait count must fit.
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    // A wait count of 0 behaves as 1 and anything above the counter range
    // saturates, so the counter can never wrap.
    function automatic int eff_wait(input int w);
        if (w < 1) begin
            return 1;
        end
        if (w > CNT_MAX) begin
            return CNT_MAX;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_ctrl
// Description : Responder for the instruction-bus RAM interface. Accepts one
//               word request at a time and runs a single access on an
//               external asynchronous 32-bit SRAM with a programmable number
//               of wait states. ram_stall stays high until the access is done.
// Ports       :
//   clk, rst            - clock, synchronous active-high reset
//   ram_addr            - byte address from the bus ([23:2] used)
//   ram_byte_enable     - write lane enables, active-high
//   ram_read_enable     - read request (level)
//   ram_write_enable    - write request (level, wins over read)
//   write_data_to_ram   - write data
//   read_data_from_ram  - read data, valid in the DONE cycle and held after
//   ram_stall           - request pending and not yet complete
//   sram_addr           - word address to the SRAM
//   sram_data_o/_i/_oe  - split SRAM data bus (tristated at top level)
//   sram_ce_n/oe_n/we_n - SRAM strobes, active-low
//   sram_be_n           - SRAM byte enables, active-low
// Revision    : 1.0 - initial release
// ============================================================================
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES     = SRAM_WAIT_DEFAULT,
    parameter int SRAM_ADDR_WIDTH = 22
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [23:0]                ram_addr,
    input  logic [3:0]                 ram_byte_enable,
    input  logic                       ram_read_enable,
    input  logic                       ram_write_enable,
    input  logic [31:0]                write_data_to_ram,
    output logic [31:0]                read_data_from_ram,
    output logic                       ram_stall,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic [31:0]                sram_data_o,
    input  logic [31:0]                sram_data_i,
    output logic                       sram_data_oe,
    output logic                       sram_ce_n,
    output logic                       sram_oe_n,
    output logic                       sram_we_n,
    output logic [3:0]                 sram_be_n
);

    localparam int             c_EFF_WAIT = eff_wait(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(c_EFF_WAIT - 1);

    sram_state_e                state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [SRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]                wdata_q, wdata_d;
    logic [3:0]                 be_q, be_d;
    logic                       is_write_q, is_write_d;
    logic [31:0]                rdata_q, rdata_d;

    logic                       w_req;
    logic                       w_unused_addr_lsb;

    assign w_req = ram_read_enable | ram_write_enable;

    // Byte-offset bits are irrelevant for word accesses.
    assign w_unused_addr_lsb = &{1'b0, ram_addr[1:0]};

    // Stall follows the live request: if the master drops the request while
    // an access is in flight, the stall drops at once but the SRAM cycle
    // still finishes.
    assign ram_stall = w_req & (state_q != SRAM_DONE);

    assign sram_addr          = addr_q;
    assign sram_data_o        = wdata_q;
    assign read_data_from_ram = rdata_q;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SRAM_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            is_write_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            is_write_q <= is_write_d;
            rdata_q    <= rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        is_write_d = is_write_q;
        rdata_d    = rdata_q;

        case (state_q)
            SRAM_IDLE: begin
                if (w_req) begin
                    addr_d     = ram_addr[SRAM_ADDR_WIDTH+1:2];
                    wdata_d    = write_data_to_ram;
                    be_d       = ram_byte_enable;
                    // A simultaneous read and write is treated as a write.
                    is_write_d = ram_write_enable;
                    cnt_d      = c_CNT_LOAD;
                    state_d    = SRAM_ACCESS;
                end
            end

            SRAM_ACCESS: begin
                if (cnt_q == '0) begin
                    if (!is_write_q) begin
                        rdata_d = sram_data_i;
                    end
                    state_d = SRAM_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            SRAM_DONE: begin
                state_d = SRAM_IDLE;
            end

            default: begin
                state_d = SRAM_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // SRAM strobes, decoded from the registered state so they deassert on
    // the same edge that reset or the access end takes effect.
    // ------------------------------------------------------------------
    always_comb begin
        sram_ce_n    = 1'b1;
        sram_oe_n    = 1'b1;
        sram_we_n    = 1'b1;
        sram_be_n    = 4'b1111;
        sram_data_oe = 1'b0;

        case (state_q)
            SRAM_ACCESS: begin
                sram_ce_n = 1'b0;
                if (is_write_q) begin
                    sram_we_n    = 1'b0;
                    sram_be_n    = ~be_q;
                    sram_data_oe = 1'b1;
                end else begin
                    sram_oe_n = 1'b0;
                    sram_be_n = 4'b0000;
                end
            end

            SRAM_DONE: begin
                // Keep driving write data one cycle past the WE# rising edge
                // to satisfy the SRAM data hold time.
                sram_data_oe = is_write_q;
            end

            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire
